// File: rtl/hilo_unit.sv
// ---------------------------------------------------------------------------
// hilo_unit
//
// HI/LO register pair for a MIPS-style multiply/divide unit. A MUL or DIV
// result is captured when the operation is launched and committed to HI/LO
// a fixed number of cycles later. MTHI/MTLO write the registers directly
// while the unit is idle. MFHI/MFLO read the committed values
// combinationally. Requests that arrive while the unit is busy are held off
// with a stall.
//
// Parameters
//   MUL_LAT      cycles from an accepted MUL start to the HI/LO update (1..63)
//   DIV_LAT      cycles from an accepted DIV start to the HI/LO update (1..63)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   start        launch a MUL/DIV writeback
//   is_div       0 = MUL, 1 = DIV (sampled with start)
//   alu_result   64-bit ALU result (sampled with start)
//   rem_in       DIV remainder (sampled with start)
//   b_zero       divisor is zero (sampled with start)
//   mt_en        MTHI/MTLO write request
//   mt_sel       target of mt_en: 0 = LO, 1 = HI
//   mt_data      MTHI/MTLO write data
//   rd_req       MFHI/MFLO read request
//   mf_sel       source of rd_data: 0 = LO, 1 = HI
//   rd_data      committed HI or LO, combinational
//   busy         operation in flight
//   stall        busy and a start, mt_en or rd_req is requested
//   done         one-cycle pulse following a commit
//   div_by_zero  sticky: last completed DIV had a zero divisor
// ---------------------------------------------------------------------------
module hilo_unit #(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_div,
    input  logic [63:0] alu_result,
    input  logic [31:0] rem_in,
    input  logic        b_zero,
    input  logic        mt_en,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    input  logic        rd_req,
    input  logic        mf_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The counter is loaded with LAT-1 so that the commit happens on the
    // LAT-th edge after the accepting edge, and busy lasts exactly LAT cycles.
    localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_LAT - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic [63:0] pending;
    logic        pend_div;
    logic        pend_bz;
    logic [31:0] hi;
    logic [31:0] lo;

    // Control FSM together with the HI/LO registers and the status flags.
    // A start while IDLE always takes priority over a simultaneous mt_en.
    // A DIV with a zero divisor still runs its full latency and pulses done,
    // but leaves HI/LO untouched and raises the sticky flag instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= '0;
            pend_div    <= 1'b0;
            pend_bz     <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    pending     <= is_div ? {rem_in, alu_result[31:0]} : alu_result;
                    pend_div    <= is_div;
                    pend_bz     <= b_zero;
                    cnt         <= is_div ? DIV_CNT_INIT : MUL_CNT_INIT;
                    div_by_zero <= 1'b0;
                    state       <= BUSY;
                end else if (mt_en) begin
                    if (mt_sel) begin
                        hi <= mt_data;
                    end else begin
                        lo <= mt_data;
                    end
                end
            end else begin
                if (cnt != 6'd0) begin
                    cnt <= cnt - 6'd1;
                end else begin
                    if (pend_div && pend_bz) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= pending[63:32];
                        lo <= pending[31:0];
                    end
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

    // Reads always see committed HI/LO; the pending result stays hidden
    // and a read during BUSY is covered by stall.
    assign rd_data = mf_sel ? hi : lo;
    assign busy    = (state == BUSY);
    assign stall   = busy & (start | mt_en | rd_req);

endmodule

// File: tb/tb_hilo_unit.sv
// ---------------------------------------------------------------------------
// tb_hilo_unit
//
// Self-checking bench for hilo_unit. A behavioural model tracks HI/LO and
// the in-flight operation by absolute edge number (commit edge = accept
// edge + latency) and a compare process checks every DUT output against it
// on each falling edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_hilo_unit;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_div = 1'b0;
    logic [63:0] alu_result = '0;
    logic [31:0] rem_in = '0;
    logic        b_zero = 1'b0;
    logic        mt_en = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = '0;
    logic        rd_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;

    hilo_unit #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_div     (is_div),
        .alu_result (alu_result),
        .rem_in     (rem_in),
        .b_zero     (b_zero),
        .mt_en      (mt_en),
        .mt_sel     (mt_sel),
        .mt_data    (mt_data),
        .rd_req     (rd_req),
        .mf_sel     (mf_sel),
        .rd_data    (rd_data),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Behavioural model: HI/LO, sticky flag, and at most one operation in
    // flight described by its result and the edge number at which it commits.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dbz = 1'b0;
    logic        m_done = 1'b0;
    logic        op_active = 1'b0;
    logic [63:0] op_data = '0;
    logic        op_bad_div = 1'b0;
    int          op_commit_edge = 0;
    int          edge_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0;
            m_lo = '0;
            m_dbz = 1'b0;
            m_done = 1'b0;
            op_active = 1'b0;
        end else begin
            edge_count = edge_count + 1;
            m_done = 1'b0;
            if (op_active) begin
                if (edge_count == op_commit_edge) begin
                    if (op_bad_div) begin
                        m_dbz = 1'b1;
                    end else begin
                        m_hi = op_data[63:32];
                        m_lo = op_data[31:0];
                    end
                    m_done = 1'b1;
                    op_active = 1'b0;
                end
            end else if (start) begin
                op_active = 1'b1;
                op_commit_edge = edge_count + (is_div ? DIV_LAT : MUL_LAT);
                op_data = is_div ? {rem_in, alu_result[31:0]} : alu_result;
                op_bad_div = is_div && b_zero;
                m_dbz = 1'b0;
            end else if (mt_en) begin
                if (mt_sel) m_hi = mt_data;
                else        m_lo = mt_data;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        checkOutput("model_busy", 64'(busy), 64'(op_active));
        checkOutput("model_done", 64'(done), 64'(m_done));
        checkOutput("model_dbz", 64'(div_by_zero), 64'(m_dbz));
        checkOutput("model_stall", 64'(stall), 64'(op_active & (start | mt_en | rd_req)));
        checkOutput("model_rd_data", 64'(rd_data), 64'(mf_sel ? m_hi : m_lo));
    end

    task automatic applyStimulus(input logic s, input logic d, input logic [63:0] alu,
                                 input logic [31:0] rem, input logic bz, input logic me,
                                 input logic ms, input logic [31:0] md, input logic rr);
        start = s;
        is_div = d;
        alu_result = alu;
        rem_in = rem;
        b_zero = bz;
        mt_en = me;
        mt_sel = ms;
        mt_data = md;
        rd_req = rr;
    endtask

    // Advance one rising edge, then drop all requests.
    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        mf_sel = ~mf_sel;
    endtask

    task automatic readReg(input logic sel, output logic [31:0] val);
        mf_sel = sel;
        #1;
        val = rd_data;
    endtask

    task automatic checkHiLo(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        logic [31:0] v;
        readReg(1'b1, v);
        checkOutput({tag, "_hi"}, 64'(v), 64'(exp_hi));
        readReg(1'b0, v);
        checkOutput({tag, "_lo"}, 64'(v), 64'(exp_lo));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'h0);
        checkOutput("reset_done", 64'(done), 64'h0);
        checkOutput("reset_dbz", 64'(div_by_zero), 64'h0);
        checkHiLo("reset", 32'h0, 32'h0);
        rst_n = 1'b1;

        // MUL on the first edge after reset release
        applyStimulus(1'b1, 1'b0, 64'h00000002_FFFFFFFE, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < MUL_LAT; i++) begin
            checkOutput("mul_busy", 64'(busy), 64'h1);
            checkOutput("mul_no_done", 64'(done), 64'h0);
            tick();
        end
        checkOutput("mul_done", 64'(done), 64'h1);
        checkOutput("mul_busy_low", 64'(busy), 64'h0);
        checkHiLo("mul", 32'h00000002, 32'hFFFFFFFE);
        tick();
        checkOutput("mul_done_pulse", 64'(done), 64'h0);

        // DIV: upper ALU half must be ignored; read during BUSY stalls
        applyStimulus(1'b1, 1'b1, 64'hDEADBEEF_00000007, 32'h3, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < DIV_LAT; i++) begin
            checkOutput("div_busy", 64'(busy), 64'h1);
            if (i == 10) begin
                rd_req = 1'b1;
                #1;
                checkOutput("div_read_stall", 64'(stall), 64'h1);
            end
            tick();
        end
        checkOutput("div_done", 64'(done), 64'h1);
        checkHiLo("div", 32'h3, 32'h7);
        tick();

        // Divide by zero with preloaded HI/LO
        applyStimulus(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h22, 1'b0);
        tick();
        checkOutput("mt_no_done", 64'(done), 64'h0);
        checkHiLo("mt", 32'h11, 32'h22);
        applyStimulus(1'b1, 1'b1, 64'h55, 32'h66, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        repeat (DIV_LAT) tick();
        checkOutput("dbz_done", 64'(done), 64'h1);
        checkOutput("dbz_flag", 64'(div_by_zero), 64'h1);
        checkHiLo("dbz", 32'h11, 32'h22);
        applyStimulus(1'b1, 1'b0, 64'h00000001_00000003, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("dbz_cleared", 64'(div_by_zero), 64'h0);
        repeat (MUL_LAT) tick();
        checkHiLo("after_dbz", 32'h1, 32'h3);
        tick();

        // Collision: start beats mt_en; mt_en during BUSY stalls and is dropped
        applyStimulus(1'b1, 1'b0, 64'h00000005_00000006, 32'h0, 1'b0, 1'b1, 1'b1, 32'hAA, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hBB, 1'b0);
        #1;
        checkOutput("busy_mt_stall", 64'(stall), 64'h1);
        tick();
        repeat (MUL_LAT - 1) tick();
        checkOutput("coll_done", 64'(done), 64'h1);
        checkHiLo("coll", 32'h5, 32'h6);
        tick();

        // Back-to-back: second start in the done cycle
        applyStimulus(1'b1, 1'b0, 64'h11112222_33334444, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        repeat (MUL_LAT) tick();
        checkOutput("b2b_first_done", 64'(done), 64'h1);
        applyStimulus(1'b1, 1'b0, 64'h55556666_77778888, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("b2b_accepted", 64'(busy), 64'h1);
        checkHiLo("b2b_first", 32'h11112222, 32'h33334444);
        for (int i = 1; i < MUL_LAT; i++) begin
            tick();
            checkOutput("b2b_early_done", 64'(done), 64'h0);
        end
        tick();
        checkOutput("b2b_second_done", 64'(done), 64'h1);
        checkHiLo("b2b_second", 32'h55556666, 32'h77778888);
        tick();

        // Abort: reset two cycles into a MUL
        applyStimulus(1'b1, 1'b0, 64'h00000007_00000008, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'h0);
        checkHiLo("abort", 32'h0, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < MUL_LAT + 2; i++) begin
            tick();
            checkOutput("abort_no_done", 64'(done), 64'h0);
            checkOutput("abort_idle", 64'(busy), 64'h0);
        end
        checkHiLo("abort_after", 32'h0, 32'h0);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter MUL_LAT, default 4, cycles from accepted MUL start to HI/LO update (legal 1..63).
REQ-002 Parameter DIV_LAT, default 32, cycles from accepted DIV start to HI/LO update (legal 1..63).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to launch a MUL/DIV writeback.
REQ-006 is_div  input  1  0 = MUL, 1 = DIV; sampled with start.
REQ-007 alu_result  input  64  ALU Result bus; sampled with start.
REQ-008 rem_in  input  32  DIV remainder; sampled with start.
REQ-009 b_zero  input  1  divisor is zero; sampled with start.
REQ-010 mt_en  input  1  MTHI/MTLO write request.
REQ-011 mt_sel  input  1  0 = LO, 1 = HI target for mt_en.
REQ-012 mt_data  input  32  MTHI/MTLO data.
REQ-013 rd_req  input  1  MFHI/MFLO read request.
REQ-014 mf_sel  input  1  0 = LO, 1 = HI source for rd_data.
REQ-015 rd_data  output  32  combinational mf_sel ? HI : LO.
REQ-016 busy  output  1  high in state BUSY.
REQ-017 stall  output  1  busy & (start | mt_en | rd_req), combinational.
REQ-018 done  output  1  registered one-cycle pulse on HI/LO commit.
REQ-019 div_by_zero  output  1  sticky flag, last completed DIV had zero divisor.

Function
REQ-020 FSM states IDLE and BUSY only.
REQ-021 IDLE & start: capture pending = MUL ? alu_result : {rem_in, alu_result[31:0]}; capture is_div and b_zero; load cnt = LAT-1 (LAT per is_div); go BUSY.
REQ-022 BUSY & cnt != 0: cnt decrements by 1 each cycle.
REQ-023 BUSY & cnt == 0: at the next edge, HI = pending[63:32] and LO = pending[31:0], done = 1 for one cycle, state goes to IDLE.
REQ-024 Timing: start accepted at edge E0, so HI/LO hold the new values and done = 1 in the cycle after edge E0+LAT; busy is high for exactly LAT cycles.
REQ-025 DIV with b_zero captured high: at completion HI/LO stay unchanged, done pulses, div_by_zero = 1.
REQ-026 div_by_zero clears to 0 on the next accepted start.
REQ-027 IDLE & mt_en & !start: the selected HI or LO takes mt_data at the edge; the other register is unchanged; no done pulse.
REQ-028 IDLE & start & mt_en in the same cycle: start wins, mt_en is dropped.
REQ-029 BUSY: start and mt_en are ignored (not queued); the requester is held by stall.
REQ-030 rd_data always reflects committed HI/LO, never pending; stall covers a read hazard during BUSY.
REQ-031 A start in the same cycle as done (IDLE) is accepted normally, giving back-to-back operation.
REQ-032 Counter width is 6 bits; no wrap-around is possible within legal LAT.

Reset
REQ-033 rst_n low: state = IDLE, HI = 0, LO = 0, cnt = 0, pending = 0, done = 0, div_by_zero = 0, busy = 0, asynchronous to clk.
REQ-034 Reset during BUSY aborts the operation: no commit and no done pulse after release.
REQ-035 First start is accepted on the first rising edge with rst_n high.

Verification
REQ-036 MUL: start, is_div = 0, alu_result = 0x00000002_FFFFFFFE -> busy for 4 cycles, then done = 1, HI = 0x00000002, LO = 0xFFFFFFFE.
REQ-037 DIV: start, is_div = 1, alu_result[31:0] = 7, rem_in = 3 -> done after 32 cycles, LO = 7, HI = 3; rd_req = 1 during BUSY -> stall = 1.
REQ-038 Divide by zero: HI = 0x11, LO = 0x22 preloaded via mt_en, then DIV with b_zero = 1 -> after 32 cycles HI = 0x11, LO = 0x22, div_by_zero = 1; next MUL start -> div_by_zero = 0.
REQ-039 Collision: IDLE, start (MUL) and mt_en (mt_sel = 1, mt_data = 0xAA) together -> MTHI dropped, HI = MUL result; mt_en during BUSY -> stall = 1, HI/LO unchanged.
REQ-040 Abort: rst_n pulsed low 2 cycles into a MUL -> HI = LO = 0, busy = 0, no done pulse.
REQ-041 Back-to-back: a second start in the done cycle -> accepted, second done exactly LAT cycles later.
